vedic_mult_pipe: RTL
====================

# vedic_mult_pipe

Parametrised, fully pipelined Vedic (Urdhva-Tiryagbhyam) multiplier for the matrix-multiplier datapath. It generalises the fixed 16x16 start/done multiplier to any power-of-two operand width and adds signed/unsigned mode per operation. It accepts one operation per cycle with valid/ready backpressure and carries a user tag alongside each product. Processing elements use it in place of the fixed-width multipliers so that product, sign mode and tag stream through together.

## Interface
- WIDTH, 16: operand width; power of two, 4..64.
- TAG_W, 8: width of the sideband tag carried with each operation; minimum 1.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation present on a, b, sgn, tag_in.
- in_ready  output  1  block accepts the operation this cycle.
- a, b  input  WIDTH  operands.
- sgn  input  1  1 = two's-complement operands and product; 0 = unsigned.
- tag_in  input  TAG_W  opaque tag, returned unchanged with the product.
- out_valid  output  1  result and tag_out are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  2*WIDTH  product.
- tag_out  output  TAG_W  tag of the operation in result.
- occupancy  output  $clog2(LAT+1)  number of operations in flight, including the one at the output.

## Operation
- Derived constant: LAT = 3 + 3*log2(WIDTH/2). WIDTH=16 gives 12, WIDTH=32 gives 15, WIDTH=4 gives 6.
- Stage 0, input conditioning: if sgn=1, the block registers |a| and |b| as WIDTH-bit unsigned values and registers neg = a[MSB]^b[MSB]. If sgn=0, it registers a and b unchanged with neg=0. For -2^(WIDTH-1), |x| = 2^(WIDTH-1), which fits in WIDTH unsigned bits.
- Stage 1: registered 2x2 base products.
- Each doubling level from N/2 to N adds 3 registered stages, same structure at every level:
  - Stage A: register hi*hi and lo*lo; compute mid = hi*lo + lo*hi at N+2 bits.
  - Stage B: mid + (lo*lo >> N/2).
  - Stage C: {hi*hi + (stage B result >> N/2), stage B result[N/2-1:0], lo*lo[N/2-1:0]}.
- The top carry out of the stage C add is discarded; the product always fits in 2N bits.
- Final stage: if neg=1, result = -magnitude (2*WIDTH two's complement), else result = magnitude. A product of zero with neg=1 yields 0.
- Unsigned mode result equals a*b modulo 2^(2*WIDTH). Signed mode result equals signed a*b exactly.
- sgn, neg and tag travel in per-stage valid-qualified shift registers aligned with the data.

## Timing
- Throughput: one operation per cycle when not stalled.
- Latency: exactly LAT cycles from the accept edge (in_valid & in_ready) to out_valid, provided no stall occurs. This holds for both modes.
- Stall: stall = out_valid & ~out_ready.
  - While stall=1, every pipeline register, including valid bits, holds.
  - in_ready = ~stall, combinational from out_valid and out_ready.
  - When out_valid=0, the pipeline advances regardless of out_ready, so bubbles collapse only at the output.
- Output hold: while out_valid=1 and out_ready=0, result and tag_out hold stable.
- occupancy: +1 on accept, -1 on an output handshake; unchanged when both happen in the same cycle. It never exceeds LAT.
- Reset values: all stage valid bits = 0, out_valid = 0, occupancy = 0, result = 0, tag_out = 0, in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded with no partial output.
- After reset, in_valid is ignored during the reset cycle itself.
- Data registers other than valid bits, result and tag_out may be left unreset.

## Test plan
- Unsigned single operation, WIDTH=16, sgn=0:
  - Stimulus: a=0xFFFF, b=0xFFFF, tag=0x5A.
  - Response: after exactly 12 cycles, out_valid=1, result=0xFFFE0001, tag_out=0x5A.
- Signed corners, WIDTH=16, sgn=1, issued back to back:
  - Stimulus: (0x8000,0x8000), (0x8000,0x7FFF), (0xFFFF,0x0001), (0x0000,0xFFFF).
  - Response, four consecutive cycles: 0x40000000, 0xC0008000, 0xFFFFFFFF, 0x00000000.
- Streaming: 1000 random operations with mixed sgn, in_valid held at 1 and out_ready=1.
  - Response: one result per cycle after the 12-cycle fill, all matching the reference model in order, occupancy steady at 12.
- Backpressure: random out_ready at 30% duty during streaming.
  - Response: no lost or duplicated result, result and tag stable while stalled, in_ready=0 exactly when out_valid&~out_ready.
- Reset mid-stream: assert reset for 1 cycle with 7 operations in flight.
  - Response: out_valid=0 and occupancy=0 on the next cycle, and no stale result appears afterwards.
- Width sweep: WIDTH=4 and WIDTH=32, exhaustive for 4 bits and random for 32 bits.
  - Response: latency 6 and 15 respectively, and all products correct in both modes.

Source files
------------

// File: rtl/vedic_mult_pipe_if.sv
// vedic_mult_pipe_if: operand/result valid-ready channel of vedic_mult_pipe.
//   master: drives in_valid, a, b, sgn, tag_in, out_ready; sees in_ready, out_valid, result, tag_out, occupancy
//   slave : the multiplier side of the same signals
interface vedic_mult_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 8
);
  localparam int LAT = 3 + 3 * $clog2(WIDTH / 2);
  localparam int OCC_W = $clog2(LAT + 1);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic sgn;
  logic [TAG_W-1:0] tag_in;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;
  logic [OCC_W-1:0] occupancy;
  modport master (
    output in_valid, a, b, sgn, tag_in, out_ready,
    input in_ready, out_valid, result, tag_out, occupancy
  );
  modport slave (
    input in_valid, a, b, sgn, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, occupancy
  );
endinterface

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: pipelined Urdhva-Tiryagbhyam multiplier, signed/unsigned per op, tagged, valid/ready.
//   clk, reset (sync, active-high); bus (slave): in_valid/in_ready/a/b/sgn/tag_in in,
//   out_valid/out_ready/result/tag_out out, occupancy = operations in flight.
module vedic_node #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         en,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [2*N-1:0] p_o
);
  if (N == 2) begin : g_base
    logic [3:0] p_q;
    always_ff @(posedge clk)
      if (en) p_q <= 4'(a_i) * 4'(b_i);
    assign p_o = p_q;
  end else begin : g_split
    localparam int H = N / 2;
    localparam int M = N + 2;
    logic [N-1:0] hh, ll, hl, lh, hh_a, ll_a, hh_b;
    logic [M-1:0] mid_a, mid_b;
    logic [H-1:0] ll_b;
    logic [2*N-1:0] p_q;
    vedic_node #(.N(H)) u_hh (.clk(clk), .en(en), .a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(hh));
    vedic_node #(.N(H)) u_ll (.clk(clk), .en(en), .a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
    vedic_node #(.N(H)) u_hl (.clk(clk), .en(en), .a_i(a_i[N-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
    vedic_node #(.N(H)) u_lh (.clk(clk), .en(en), .a_i(a_i[H-1:0]), .b_i(b_i[N-1:H]), .p_o(lh));
    // Three stages per level: cross sum, fold in lo*lo carry, assemble (top carry dropped).
    always_ff @(posedge clk)
      if (en) begin
        hh_a  <= hh;
        ll_a  <= ll;
        mid_a <= M'(hl) + M'(lh);
        hh_b  <= hh_a;
        ll_b  <= ll_a[H-1:0];
        mid_b <= mid_a + M'(ll_a >> H);
        p_q   <= {hh_b + N'(mid_b >> H), mid_b[H-1:0], ll_b};
      end
    assign p_o = p_q;
  end
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 8
) (
  input logic clk,
  input logic reset,
  vedic_mult_pipe_if.slave bus
);
  localparam int LAT = 3 + 3 * $clog2(WIDTH / 2);
  localparam int OCC_W = $clog2(LAT + 1);
  logic en, acc, neg_d;
  logic [WIDTH-1:0] ua_d, ub_d, ua_q, ub_q;
  logic [2*WIDTH-1:0] mag, res_d, res_q;
  logic [LAT-1:0] v_q;
  logic [LAT-2:0] neg_q;
  logic [TAG_W-1:0] tag_q [LAT-1];
  logic [TAG_W-1:0] tag_o_q;
  logic [OCC_W-1:0] occ_d, occ_q;
  always_comb begin
    en    = ~(v_q[LAT-1] & ~bus.out_ready);
    acc   = bus.in_valid & en;
    ua_d  = bus.sgn & bus.a[WIDTH-1] ? -bus.a : bus.a;
    ub_d  = bus.sgn & bus.b[WIDTH-1] ? -bus.b : bus.b;
    neg_d = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    res_d = neg_q[LAT-2] ? -mag : mag;
    occ_d = occ_q + OCC_W'(acc) - OCC_W'(v_q[LAT-1] & bus.out_ready);
  end
  vedic_node #(.N(WIDTH)) u_core (.clk(clk), .en(en), .a_i(ua_q), .b_i(ub_q), .p_o(mag));
  always_ff @(posedge clk)
    if (reset) begin
      v_q     <= '0;
      occ_q   <= '0;
      res_q   <= '0;
      tag_o_q <= '0;
    end else if (en) begin
      v_q     <= {v_q[LAT-2:0], acc};
      occ_q   <= occ_d;
      res_q   <= res_d;
      tag_o_q <= tag_q[LAT-2];
    end
  always_ff @(posedge clk)
    if (en) begin
      ua_q     <= ua_d;
      ub_q     <= ub_d;
      neg_q    <= {neg_q[LAT-3:0], neg_d};
      tag_q[0] <= bus.tag_in;
      for (int i = 1; i < LAT - 1; i++) tag_q[i] <= tag_q[i-1];
    end
  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[LAT-1];
  assign bus.result    = res_q;
  assign bus.tag_out   = tag_o_q;
  assign bus.occupancy = occ_q;
endmodule
